// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_pkg: shared widths, PC register index and write-back types   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package regfile_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] PC_REG = 4'hF;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic is_pc_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr == PC_REG;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin grant from (valid, ptr)         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx,
  output logic            grant_any
);

  // Scan from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!grant_any && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_wb_arbiter: round-robin write-back arbiter for the register  |
// | file write port, with R15 writes redirected to the PC load path.      |
// | Optional macro REGFILE_WB_BYPASS_EN: forward the pending write to RD. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int N    = REG_ADDR_W,
  parameter int M    = REG_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_addr,
  input  logic [NREQ*M-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rf_we,
  output logic [N-1:0]      rf_a3,
  output logic [M-1:0]      rf_wd3,
  output logic              pc_load,
  output logic [M-1:0]      pc_value,
  input  logic [N-1:0]      rf_a1,
  input  logic [N-1:0]      rf_a2,
  input  logic [M-1:0]      rf_rd1,
  input  logic [M-1:0]      rf_rd2,
  output logic [M-1:0]      byp_rd1,
  output logic [M-1:0]      byp_rd2,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [N-1:0] PC_ADDR = N'(PC_REG);

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   next_ptr;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic            grant_any;
  logic [N-1:0]    sel_addr;
  logic [M-1:0]    sel_data;
  logic            we_q;
  logic            pcl_q;

  assign eligible = req_valid & {NREQ{~hold & reset}};

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .valid     (eligible),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;
  assign next_ptr  = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*N +: N];
        sel_data = req_data[i*M +: M];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr   <= '0;
      we_q     <= 1'b0;
      pcl_q    <= 1'b0;
      rf_a3    <= '0;
      rf_wd3   <= '0;
      pc_value <= '0;
    end else begin
      we_q  <= 1'b0;
      pcl_q <= 1'b0;
      if (grant_any) begin
        rr_ptr <= next_ptr;
        if (sel_addr == PC_ADDR) begin
          pcl_q    <= 1'b1;
          pc_value <= sel_data;
        end else begin
          we_q   <= 1'b1;
          rf_a3  <= sel_addr;
          rf_wd3 <= sel_data;
        end
      end
    end
  end

  // A staged write is suppressed while reset is low so it never reaches the file.
  assign rf_we   = we_q & reset;
  assign pc_load = pcl_q & reset;
  assign busy    = (|req_valid) | rf_we | pc_load;

`ifdef REGFILE_WB_BYPASS_EN
  assign byp_rd1 = (rf_we && rf_a1 == rf_a3 && rf_a1 != PC_ADDR) ? rf_wd3 : rf_rd1;
  assign byp_rd2 = (rf_we && rf_a2 == rf_a3 && rf_a2 != PC_ADDR) ? rf_wd3 : rf_rd2;
`else
  logic unused_bypass;
  assign unused_bypass = ^{rf_a1, rf_a2};
  assign byp_rd1 = rf_rd1;
  assign byp_rd2 = rf_rd2;
`endif

endmodule
`default_nettype wire
